// File: rtl/ofmap_packer.sv
// ofmap_packer: adds bias to signed accumulator results and requantizes them to int8
// with round-half-up, optional ReLU and saturation. Results are packed four lanes per
// stream word, element 0 in the LSB byte. The last word of a layer carries out_last.
//
// state  | meaning
// -------+------------------------------------------------------------------
// IDLE   | waiting for cfg_start; no inputs accepted
// RUN    | accepting elements until cfg_total have been taken
// DRAIN  | pipeline emptying; waiting for the out_last word to be handshaken
// DONE   | single cycle with done=1, then back to IDLE
module ofmap_packer #(
  parameter int ACC_WIDTH            = 32,
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int CNT_WIDTH            = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cfg_start,
  input  logic [CNT_WIDTH-1:0]            cfg_total,
  input  logic [4:0]                      cfg_shift,
  input  logic                            cfg_relu,
  input  logic                            acc_valid,
  output logic                            acc_ready,
  input  logic [ACC_WIDTH-1:0]            acc_data,
  input  logic [ACC_WIDTH-1:0]            acc_bias,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0] out_data,
  output logic                            out_last,
  output logic                            busy,
  output logic                            done
);

  localparam int LANES  = C_M_AXIS_TDATA_WIDTH / 8;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int SUM_W  = ACC_WIDTH + 1;
  // Two guard bits above the sum so the rounding increment can never wrap.
  localparam int QW     = ACC_WIDTH + 3;
  localparam logic signed [QW-1:0]    Q_MAX   = QW'(127);
  localparam logic signed [QW-1:0]    Q_MIN   = QW'(-128);
  localparam logic [CNT_WIDTH-1:0]    CNT_ONE = CNT_WIDTH'(1);
  localparam logic [LANE_W-1:0]       LANE_LAST = LANE_W'(LANES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                            state_q, state_d;
  logic [CNT_WIDTH-1:0]              total_q, total_d;
  logic [4:0]                        shift_q, shift_d;
  logic                              relu_q, relu_d;
  logic [CNT_WIDTH-1:0]              acc_cnt_q, acc_cnt_d;

  logic                              s1_valid_q, s1_valid_d;
  logic signed [SUM_W-1:0]           s1_sum_q, s1_sum_d;
  logic                              s1_last_q, s1_last_d;

  logic                              s2_valid_q, s2_valid_d;
  logic [7:0]                        s2_data_q, s2_data_d;
  logic                              s2_last_q, s2_last_d;

  logic [LANE_W-1:0]                 lane_q, lane_d;
  logic [C_M_AXIS_TDATA_WIDTH-1:0]   word_q, word_d;

  logic                              out_valid_q, out_valid_d;
  logic [C_M_AXIS_TDATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                              out_last_q, out_last_d;

  logic                              out_fire, pack_done, pack_stall;
  logic                              s2_adv, s1_adv, acc_fire;

  logic signed [QW-1:0]              q_ext, q_rnd, q_shr;
  logic [7:0]                        q_byte;
  logic [C_M_AXIS_TDATA_WIDTH-1:0]   pack_word;

  // Handshake and stall chain: the pack stage only blocks when it must hand a finished
  // word to an output register that is still holding the previous one.
  assign out_fire   = out_valid_q & out_ready;
  assign pack_done  = s2_valid_q & ((lane_q == LANE_LAST) | s2_last_q);
  assign pack_stall = pack_done & out_valid_q & ~out_ready;
  assign s2_adv     = ~s2_valid_q | ~pack_stall;
  assign s1_adv     = ~s1_valid_q | s2_adv;
  assign acc_ready  = (state_q == S_RUN) & (acc_cnt_q < total_q) & s1_adv;
  assign acc_fire   = acc_ready & acc_valid;

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);

  // Requantize the S1 sum: round-half-up, arithmetic shift, optional ReLU, saturate.
  always_comb begin
    q_ext  = {{2{s1_sum_q[SUM_W-1]}}, s1_sum_q};
    q_rnd  = '0;
    if (shift_q != 5'd0) begin
      q_rnd = QW'(1) << (shift_q - 5'd1);
    end
    q_shr  = (q_ext + q_rnd) >>> shift_q;
    if (relu_q && q_shr[QW-1]) begin
      q_shr = '0;
    end
    if (!q_shr[QW-1] && (q_shr > Q_MAX)) begin
      q_byte = 8'h7F;
    end else if (q_shr[QW-1] && (q_shr < Q_MIN)) begin
      q_byte = 8'h80;
    end else begin
      q_byte = q_shr[7:0];
    end
  end

  // Next-state logic for the control FSM, pipeline stages, lane packer and output register.
  always_comb begin
    state_d     = state_q;
    total_d     = total_q;
    shift_d     = shift_q;
    relu_d      = relu_q;
    acc_cnt_d   = acc_cnt_q;
    s1_valid_d  = s1_valid_q;
    s1_sum_d    = s1_sum_q;
    s1_last_d   = s1_last_q;
    s2_valid_d  = s2_valid_q;
    s2_data_d   = s2_data_q;
    s2_last_d   = s2_last_q;
    lane_d      = lane_q;
    word_d      = word_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    pack_word   = word_q;

    unique case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          total_d   = cfg_total;
          shift_d   = cfg_shift;
          relu_d    = cfg_relu;
          acc_cnt_d = '0;
          state_d   = (cfg_total == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (acc_fire && (acc_cnt_q == total_q - CNT_ONE)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_fire && out_last_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (acc_fire) begin
      acc_cnt_d = acc_cnt_q + CNT_ONE;
    end

    if (s1_adv) begin
      s1_valid_d = acc_fire;
      if (acc_fire) begin
        s1_sum_d  = $signed({acc_data[ACC_WIDTH-1], acc_data}) +
                    $signed({acc_bias[ACC_WIDTH-1], acc_bias});
        s1_last_d = (acc_cnt_q == total_q - CNT_ONE);
      end
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = q_byte;
        s2_last_d = s1_last_q;
      end
    end

    if (out_fire) begin
      out_valid_d = 1'b0;
    end

    if (s2_valid_q && !pack_stall) begin
      pack_word[{lane_q, 3'b000} +: 8] = s2_data_q;
      if (pack_done) begin
        out_data_d  = pack_word;
        out_last_d  = s2_last_q;
        out_valid_d = 1'b1;
        word_d      = '0;
        lane_d      = '0;
      end else begin
        word_d = pack_word;
        lane_d = lane_q + LANE_W'(1);
      end
    end
  end

  // State register; synchronous reset discards any partially packed word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      total_q     <= '0;
      shift_q     <= '0;
      relu_q      <= 1'b0;
      acc_cnt_q   <= '0;
      s1_valid_q  <= 1'b0;
      s1_sum_q    <= '0;
      s1_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      s2_last_q   <= 1'b0;
      lane_q      <= '0;
      word_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      total_q     <= total_d;
      shift_q     <= shift_d;
      relu_q      <= relu_d;
      acc_cnt_q   <= acc_cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_sum_q    <= s1_sum_d;
      s1_last_q   <= s1_last_d;
      s2_valid_q  <= s2_valid_d;
      s2_data_q   <= s2_data_d;
      s2_last_q   <= s2_last_d;
      lane_q      <= lane_d;
      word_q      <= word_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule
